// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: drives six active-low 7-segment displays from a 32-bit value.
// Modes: raw segment passthrough, hexadecimal, unsigned decimal, signed decimal.
// Decimal conversion is a sequential shift-add-3 engine behind a small FSM.
module hex_display_ctrl #(
    parameter int XLEN   = 32,
    parameter int DIGITS = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] hex_value,
    input  logic [XLEN-1:0] hex_mode,
    input  logic [6:0]      hex_raw0,
    input  logic [6:0]      hex_raw1,
    input  logic [6:0]      hex_raw2,
    input  logic [6:0]      hex_raw3,
    input  logic [6:0]      hex_raw4,
    input  logic [6:0]      hex_raw5,
    output logic [6:0]      HEX0,
    output logic [6:0]      HEX1,
    output logic [6:0]      HEX2,
    output logic [6:0]      HEX3,
    output logic [6:0]      HEX4,
    output logic [6:0]      HEX5,
    output logic            busy
);

    localparam int BCDW = 4 * DIGITS;
    localparam int CW   = $clog2(XLEN);

    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [1:0] MODE_RAW  = 2'd0;
    localparam logic [1:0] MODE_HEX  = 2'd1;
    localparam logic [1:0] MODE_SDEC = 2'd3;

    localparam logic [XLEN-1:0] UDEC_MAX = XLEN'(32'd999999);
    localparam logic [XLEN-1:0] SDEC_MAX = XLEN'(32'd99999);
    localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    // Active-low glyph for one hex digit (0-9, A-F).
    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic              r_busy;
    logic [XLEN-1:0]   r_value;
    logic [2:0]        r_mode;
    logic [XLEN-1:0]   r_shift;
    logic [BCDW-1:0]   r_bcd;
    logic [CW-1:0]     r_count;
    logic [6:0]        r_hex [DIGITS];

    logic              w_change;
    logic              w_in_neg;
    logic [XLEN-1:0]   w_load;
    logic [BCDW-1:0]   w_bcd_adj;
    logic              w_neg;
    logic [XLEN-1:0]   w_mag;
    logic              w_ovf;
    logic              w_seen;
    logic [3:0]        w_digit [DIGITS];
    logic [6:0]        w_disp  [DIGITS];
    logic [6:0]        w_raw   [DIGITS];
    logic              w_unused_mode;

    assign w_raw[0] = hex_raw0;
    assign w_raw[1] = hex_raw1;
    assign w_raw[2] = hex_raw2;
    assign w_raw[3] = hex_raw3;
    assign w_raw[4] = hex_raw4;
    assign w_raw[5] = hex_raw5;

    assign w_unused_mode = ^hex_mode[XLEN-1:3];

    // Input change detection and shift-register load value (magnitude for signed mode).
    always_comb begin
        w_change = (hex_value != r_value) || (hex_mode[2:0] != r_mode);
        w_in_neg = (hex_mode[1:0] == MODE_SDEC) && hex_value[XLEN-1];
        if (w_in_neg) begin
            w_load = ~hex_value + ONE_X;
        end else begin
            w_load = hex_value;
        end
    end

    // State register plus registered busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state logic: convert for decimal modes, update directly otherwise.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_change) begin
                    if (hex_mode[1]) begin
                        w_next_state = S_CONVERT;
                    end else begin
                        w_next_state = S_UPDATE;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CONVERT: begin
                if (r_count == LAST_CNT) begin
                    w_next_state = S_UPDATE;
                end else begin
                    w_next_state = S_CONVERT;
                end
            end
            S_UPDATE: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Latch inputs on change and run the double-dabble datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
            r_mode  <= 3'd0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_change) begin
                        r_value <= hex_value;
                        r_mode  <= hex_mode[2:0];
                        r_shift <= w_load;
                        r_bcd   <= '0;
                        r_count <= '0;
                    end
                end
                S_CONVERT: begin
                    r_bcd   <= {w_bcd_adj[BCDW-2:0], r_shift[XLEN-1]};
                    r_shift <= {r_shift[XLEN-2:0], 1'b0};
                    r_count <= r_count + ONE_C;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Sign, magnitude and overflow of the latched value.
    always_comb begin
        w_neg = (r_mode[1:0] == MODE_SDEC) && r_value[XLEN-1];
        if (w_neg) begin
            w_mag = ~r_value + ONE_X;
        end else begin
            w_mag = r_value;
        end
        case (r_mode[1:0])
            2'd2:      w_ovf = (r_value > UDEC_MAX);
            MODE_SDEC: w_ovf = (w_mag > SDEC_MAX);
            default:   w_ovf = 1'b0;
        endcase
    end

    // Per-display digit source: raw nibbles in hex mode, BCD digits otherwise.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (r_mode[1:0] == MODE_HEX) begin
                w_digit[i] = r_value[4*i +: 4];
            end else begin
                w_digit[i] = r_bcd[4*i +: 4];
            end
        end
    end

    // Glyph selection, scanning from HEX5 down so leading zeros can be blanked.
    always_comb begin
        w_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_disp[i] = GLYPH_BLANK;
            if (w_ovf) begin
                w_disp[i] = GLYPH_DASH;
            end else if ((r_mode[1:0] == MODE_SDEC) && (i == DIGITS - 1)) begin
                w_disp[i] = w_neg ? GLYPH_DASH : GLYPH_BLANK;
            end else if (r_mode[2] && !w_seen && (w_digit[i] == 4'd0) && (i != 0)) begin
                w_disp[i] = GLYPH_BLANK;
            end else begin
                w_disp[i] = seg_glyph(w_digit[i]);
                w_seen    = 1'b1;
            end
        end
    end

    // Display registers: raw path follows the live mode; converted result lands only in UPDATE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_hex[i] <= GLYPH_BLANK;
            end
        end else if (hex_mode[1:0] == MODE_RAW) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_hex[i] <= ~w_raw[i];
            end
        end else if ((r_state == S_UPDATE) && (r_mode[1:0] != MODE_RAW)) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_hex[i] <= w_disp[i];
            end
        end
    end

    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];
    assign busy = r_busy;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_hex_display_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] hex_value;
    logic [31:0] hex_mode;
    logic [6:0]  hex_raw0, hex_raw1, hex_raw2, hex_raw3, hex_raw4, hex_raw5;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_v;
    logic [2:0]  prev_m;

    localparam logic [41:0] ALL_DASH  = {6{7'h3F}};
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    hex_display_ctrl #(.XLEN(32), .DIGITS(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .hex_value (hex_value),
        .hex_mode  (hex_mode),
        .hex_raw0  (hex_raw0),
        .hex_raw1  (hex_raw1),
        .hex_raw2  (hex_raw2),
        .hex_raw3  (hex_raw3),
        .hex_raw4  (hex_raw4),
        .hex_raw5  (hex_raw5),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] dut_disp();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic logic [41:0] raw_disp();
        return {~hex_raw5, ~hex_raw4, ~hex_raw3, ~hex_raw2, ~hex_raw1, ~hex_raw0};
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
            12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected display for modes 1-3, from plain arithmetic on the value.
    function automatic logic [41:0] model_disp(input logic [31:0] v, input logic [2:0] m);
        int d [6];
        logic [6:0] g [6];
        longint unsigned x;
        bit neg;
        int top;
        neg = 1'b0;
        top = 5;
        if (m[1:0] == 2'd1) begin
            for (int i = 0; i < 6; i++) d[i] = int'((v >> (4 * i)) & 32'hF);
        end else if (m[1:0] == 2'd2) begin
            x = {32'd0, v};
            if (x > 64'd999999) return ALL_DASH;
            for (int i = 0; i < 6; i++) begin
                d[i] = int'(x % 64'd10);
                x = x / 64'd10;
            end
        end else begin
            neg = v[31];
            x = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
            if (x > 64'd99999) return ALL_DASH;
            top = 4;
            for (int i = 0; i < 6; i++) begin
                d[i] = int'(x % 64'd10);
                x = x / 64'd10;
            end
        end
        for (int i = 0; i < 6; i++) g[i] = glyph(d[i]);
        if (m[2]) begin
            for (int i = top; i >= 1; i--) begin
                if (d[i] != 0) break;
                g[i] = 7'h7F;
            end
        end
        if (m[1:0] == 2'd3) g[5] = neg ? 7'h3F : 7'h7F;
        return {g[5], g[4], g[3], g[2], g[1], g[0]};
    endfunction

    // Step clock edges until busy is seen low (sampled 1 time unit after each edge), bounded.
    task automatic wait_idle(output int edges, output int busy_hi);
        edges   = 0;
        busy_hi = 0;
        while (edges < 200) begin
            @(posedge clock);
            #1;
            edges++;
            if (busy) busy_hi++;
            else break;
        end
    endtask

    task automatic run_txn(input logic [31:0] v, input logic [31:0] m, input string tag);
        int e, b, lat;
        @(negedge clock);
        hex_value = v;
        hex_mode  = m;
        prev_v    = v;
        prev_m    = m[2:0];
        wait_idle(e, b);
        lat = (m[1:0] == 2'd1) ? 2 : 34;
        check({tag, "_lat"}, 64'(e), 64'(lat));
        check({tag, "_busy"}, 64'(b), 64'(lat - 1));
        check({tag, "_disp"}, 64'(dut_disp()), 64'(model_disp(v, m[2:0])));
    endtask

    logic [31:0] bounds [10] = '{32'd0, 32'd999999, 32'd1000000, 32'd99999, 32'd100000,
                                 32'hFFFE7961, 32'hFFFE7960, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};

    initial begin
        int e, b, seen_busy, kind;
        logic [31:0] v, m;
        logic [41:0] r;

        reset = 1'b0;
        hex_value = 32'd0;
        hex_mode  = 32'd0;
        {hex_raw0, hex_raw1, hex_raw2, hex_raw3, hex_raw4, hex_raw5} = 42'd0;
        prev_v = 32'd0;
        prev_m = 3'd0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_disp", 64'(dut_disp()), 64'(ALL_BLANK));
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (busy) seen_busy++;
        end
        check("idle_busy", 64'(seen_busy), 64'd0);
        check("idle_disp", 64'(dut_disp()), 64'(ALL_BLANK));

        // Directed scenarios with literal expected displays.
        run_txn(32'h12ABCDEF, 32'd1, "hex");
        check("hex_const", 64'(dut_disp()), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        run_txn(32'd123456, 32'd2, "udec");
        check("udec_const", 64'(dut_disp()), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        run_txn(32'd1000000, 32'd2, "udec_ovf");
        check("udec_ovf_const", 64'(dut_disp()), 64'(ALL_DASH));
        run_txn(32'hFFFFFFF9, 32'd7, "sdec");
        check("sdec_const", 64'(dut_disp()), 64'({7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}));
        run_txn(32'h80000000, 32'd7, "sdec_min");
        check("sdec_min_const", 64'(dut_disp()), 64'(ALL_DASH));

        // Value changes mid-conversion: first result shows, then a second conversion.
        @(negedge clock);
        hex_value = 32'd5;
        hex_mode  = 32'd2;
        repeat (10) @(posedge clock);
        @(negedge clock);
        hex_value = 32'd42;
        wait_idle(e, b);
        check("mid_lat1", 64'(e + 10), 64'd34);
        check("mid_disp1", 64'(dut_disp()), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12}));
        @(posedge clock);
        #1;
        check("mid_rebusy", 64'(busy), 64'd1);
        wait_idle(e, b);
        check("mid_lat2", 64'(e + 1), 64'd34);
        check("mid_disp2", 64'(dut_disp()), 64'(model_disp(32'd42, 3'd2)));
        prev_v = 32'd42;
        prev_m = 3'd2;

        // Switch to raw mode while converting: raw wins at once, update discarded.
        @(negedge clock);
        hex_value = 32'd777;
        repeat (5) @(posedge clock);
        @(negedge clock);
        hex_mode = 32'd0;
        {hex_raw5, hex_raw4, hex_raw3, hex_raw2, hex_raw1, hex_raw0} = {$urandom, $urandom};
        r = raw_disp();
        @(posedge clock);
        #1;
        check("sw_raw_now", 64'(dut_disp()), 64'(r));
        wait_idle(e, b);
        repeat (5) @(posedge clock);
        #1;
        check("sw_raw_keep", 64'(dut_disp()), 64'(r));
        check("sw_busy", 64'(busy), 64'd0);

        // Reset during conversion.
        @(negedge clock);
        hex_value = 32'd123;
        hex_mode  = 32'd2;
        repeat (15) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("arst_disp", 64'(dut_disp()), 64'(ALL_BLANK));
        check("arst_busy", 64'(busy), 64'd0);
        hex_mode  = 32'd0;
        hex_value = 32'd0;
        {hex_raw5, hex_raw4, hex_raw3, hex_raw2, hex_raw1, hex_raw0} = 42'd0;
        hex_raw0 = 7'h3F;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("arst_raw0", 64'(HEX0), 64'h40);
        check("arst_raw", 64'(dut_disp()), 64'({{5{7'h7F}}, 7'h40}));
        prev_v = 32'd0;
        prev_m = 3'd0;
        repeat (3) @(posedge clock);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0) begin
                @(negedge clock);
                hex_mode = {$urandom, 3'b000} | (32'($urandom_range(0, 1)) << 2);
                hex_mode[1:0] = 2'd0;
                {hex_raw5, hex_raw4, hex_raw3, hex_raw2, hex_raw1, hex_raw0} = {$urandom, $urandom};
                prev_m = hex_mode[2:0];
                r = raw_disp();
                @(posedge clock);
                #1;
                check("rnd_raw", 64'(dut_disp()), 64'(r));
                repeat (3) @(posedge clock);
            end else begin
                case ($urandom_range(0, 5))
                    0: v = $urandom_range(0, 999);
                    1: v = $urandom_range(0, 1100000);
                    2: v = $urandom;
                    3: v = 32'd0 - 32'($urandom_range(0, 120000));
                    4: v = bounds[$urandom_range(0, 9)];
                    default: v = $urandom_range(0, 32'hFFFFFF);
                endcase
                m = {$urandom, 3'b000};
                m[2]   = $urandom_range(0, 1) == 1;
                m[1:0] = 2'($urandom_range(1, 3));
                if (v == prev_v && m[2:0] == prev_m) v = v ^ 32'd1;
                run_txn(v, m, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
